hit_score_ctrl: RTL and testbench

Downstream consumer of the gun's shot pulse and aim coordinates.
- Each shot is tested against the on-screen enemy's hitbox.
- The block sequences the enemy through alive / hit-flash / dead / respawn.
- It keeps a 6-digit BCD score.
- Its outputs drive the enemy renderer's alive/flash inputs, the hit sound trigger and the HEX score display at the top level.

---
 rtl/hit_score_if.sv | 42 ++++
 rtl/hit_score_ctrl.sv | 131 +++++++++++++
 tb/tb_hit_score_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hit_score_if.sv
// hit_score_if: shot, enemy position and score/status signals around hit_score_ctrl
// Signals:
//   start            new-game request (level)
//   shot             one-cycle gun pulse; shoot_x/shoot_y valid with it
//   x_me, y_me       enemy top-left corner
//   alive, flash     enemy renderer controls
//   hit              one-cycle pulse per registered hit
//   score_bcd        six BCD digits, [3:0] is the ones digit
//   hex0..hex5       active-low seven-segment digits (only with HIT_SCORE_HEX_EN)
// slave: the controller side; master: the driving/observing side.
interface hit_score_if;
    logic        start;
    logic        shot;
    logic [9:0]  shoot_x;
    logic [8:0]  shoot_y;
    logic [9:0]  x_me;
    logic [8:0]  y_me;
    logic        alive;
    logic        flash;
    logic        hit;
    logic [23:0] score_bcd;
`ifdef HIT_SCORE_HEX_EN
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    modport slave (
        input  start, shot, shoot_x, shoot_y, x_me, y_me,
        output alive, flash, hit, score_bcd, hex0, hex1, hex2, hex3, hex4, hex5
    );
    modport master (
        output start, shot, shoot_x, shoot_y, x_me, y_me,
        input  alive, flash, hit, score_bcd, hex0, hex1, hex2, hex3, hex4, hex5
    );
`else
    modport slave (
        input  start, shot, shoot_x, shoot_y, x_me, y_me,
        output alive, flash, hit, score_bcd
    );
    modport master (
        output start, shot, shoot_x, shoot_y, x_me, y_me,
        input  alive, flash, hit, score_bcd
    );
`endif
endinterface

// File: rtl/hit_score_ctrl.sv
// hit_score_ctrl: enemy hit test, alive/flash/dead/respawn sequencing and 6-digit BCD score
// Ports:
//   clk    system clock (CLOCK_50 domain)
//   reset  asynchronous active-low reset
//   bus    hit_score_if.slave: start, shot, shoot_x/y, x_me/y_me in; alive, flash, hit, score_bcd out
// Optional: define HIT_SCORE_HEX_EN to add registered, leading-zero-blanked hex0..hex5 outputs.
module hit_score_ctrl #(
    parameter int HIT_W       = 32,
    parameter int HIT_H       = 32,
    parameter int FLASH_CYC   = 12_500_000,
    parameter int RESPAWN_CYC = 50_000_000
) (
    input logic        clk,
    input logic        reset,
    hit_score_if.slave bus
);
    localparam int MAXC = FLASH_CYC > RESPAWN_CYC ? FLASH_CYC : RESPAWN_CYC;
    localparam int TW   = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] FLASH_LD = TW'(FLASH_CYC - 1);
    localparam logic [TW-1:0] RESP_LD  = TW'(RESPAWN_CYC - 1);

    typedef enum logic [1:0] {IDLE, ALIVE, FLASH, DEAD} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [23:0]   score_q;
    logic [23:0]   score_inc;
    logic          carry;
    logic          alive_q;
    logic          flash_q;
    logic          hit_q;
    logic          in_box;
    logic [10:0]   x_hi;
    logic [9:0]    y_hi;

    if (HIT_W < 1 || HIT_H < 1 || FLASH_CYC < 1 || RESPAWN_CYC < 1) begin : g_bad_param
        $error("hit_score_ctrl: HIT_W, HIT_H, FLASH_CYC and RESPAWN_CYC must all be >= 1");
    end

    // Upper bounds carry one extra bit so a hitbox near the screen edge never wraps.
    assign x_hi   = {1'b0, bus.x_me} + 11'(HIT_W - 1);
    assign y_hi   = {1'b0, bus.y_me} + 10'(HIT_H - 1);
    assign in_box = bus.shoot_x >= bus.x_me && {1'b0, bus.shoot_x} <= x_hi &&
                    bus.shoot_y >= bus.y_me && {1'b0, bus.shoot_y} <= y_hi;

    // Full ripple of the BCD +1 in one cycle.
    always_comb begin
        score_inc = score_q;
        carry     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            score_inc[4*i +: 4] = carry ? (score_q[4*i +: 4] == 4'd9 ? 4'd0 : score_q[4*i +: 4] + 4'd1)
                                        : score_q[4*i +: 4];
            carry = carry && score_q[4*i +: 4] == 4'd9;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            timer   <= '0;
            score_q <= '0;
            alive_q <= 1'b0;
            flash_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            if (bus.start) begin
                state   <= ALIVE;
                timer   <= '0;
                score_q <= '0;
                alive_q <= 1'b1;
                flash_q <= 1'b0;
            end else begin
                case (state)
                    ALIVE: if (bus.shot && in_box) begin
                        state   <= FLASH;
                        timer   <= FLASH_LD;
                        hit_q   <= 1'b1;
                        alive_q <= 1'b0;
                        flash_q <= 1'b1;
                        score_q <= score_q == 24'h999999 ? score_q : score_inc;
                    end
                    FLASH: if (timer == '0) begin
                        state   <= DEAD;
                        timer   <= RESP_LD;
                        flash_q <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                    DEAD: if (timer == '0) begin
                        state   <= ALIVE;
                        alive_q <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.alive     = alive_q;
    assign bus.flash     = flash_q;
    assign bus.hit       = hit_q;
    assign bus.score_bcd = score_q;

`ifdef HIT_SCORE_HEX_EN
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };
    logic [6:0] hex_q [6];

    // Digit i is blank when it and every digit above it are zero; hex0 is never blanked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) hex_q[i] <= 7'h7F;
        end else begin
            for (int i = 0; i < 6; i++)
                hex_q[i] <= (i > 0 && (score_q >> (4*i)) == 24'd0) ? 7'h7F : SEG[score_q[4*i +: 4]];
        end
    end

    assign bus.hex0 = hex_q[0];
    assign bus.hex1 = hex_q[1];
    assign bus.hex2 = hex_q[2];
    assign bus.hex3 = hex_q[3];
    assign bus.hex4 = hex_q[4];
    assign bus.hex5 = hex_q[5];
`endif
endmodule

// File: tb/tb_hit_score_ctrl.sv
// tb_hit_score_ctrl: directed and randomized checks of hit_score_ctrl against a timeline model
module tb_hit_score_ctrl;
    localparam int F = 4;
    localparam int R = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    hit_score_if bus ();

    hit_score_ctrl #(.FLASH_CYC(F), .RESPAWN_CYC(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Model: game started flag, edge at which the last hit registered, decimal score, expected hit pulse.
    bit m_started = 0;
    int m_t_hit   = -1;
    int m_score   = 0;
    bit m_hit     = 0;

    // 0 idle, 1 alive, 2 flash, 3 dead -- state holding after edge e, derived from the hit time.
    function automatic int state_at(int e);
        if (!m_started) return 0;
        if (m_t_hit < 0 || e >= m_t_hit + F + R) return 1;
        return e < m_t_hit + F ? 2 : 3;
    endfunction

    function automatic logic [23:0] to_bcd(int s);
        logic [23:0] r = '0;
        int p = 1;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'((s / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("alive", 32'(bus.alive), 32'(state_at(cyc) == 1));
        chk("flash", 32'(bus.flash), 32'(state_at(cyc) == 2));
        chk("hit",   32'(bus.hit),   32'(m_hit));
        chk("score", 32'(bus.score_bcd), 32'(to_bcd(m_score)));
    endtask

    task automatic model_reset();
        m_started = 0;
        m_t_hit   = -1;
        m_score   = 0;
        m_hit     = 0;
    endtask

    // Called at a negedge; drives one cycle of inputs, checks #1 after the posedge, returns at the next negedge.
    task automatic step(bit st, bit sh, int x, int y);
        bit prev_alive;
        bus.start   = st;
        bus.shot    = sh;
        bus.shoot_x = 10'(x);
        bus.shoot_y = 9'(y);
        @(posedge clk);
        prev_alive = state_at(cyc) == 1;
        cyc++;
        if (!reset) model_reset();
        else if (st) begin
            m_started = 1;
            m_t_hit   = -1;
            m_score   = 0;
            m_hit     = 0;
        end else if (sh && prev_alive &&
                     x >= int'(bus.x_me) && x <= int'(bus.x_me) + 31 &&
                     y >= int'(bus.y_me) && y <= int'(bus.y_me) + 31) begin
            m_t_hit = cyc;
            m_score = m_score < 999999 ? m_score + 1 : m_score;
            m_hit   = 1;
        end else m_hit = 0;
        #1 check_all();
        @(negedge clk);
        bus.start = 1'b0;
        bus.shot  = 1'b0;
    endtask

    task automatic wait_alive();
        for (int i = 0; i < 30 && !bus.alive; i++) step(0, 0, 0, 0);
        chk("wait_alive", 32'(bus.alive), 32'd1);
    endtask

    task automatic preload(int dec, logic [23:0] bcd);
        force dut.score_q = bcd;
        #1 release dut.score_q;
        m_score = dec;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_flash;
        int xm;
        int ym;
        bus.start   = 1'b0;
        bus.shot    = 1'b0;
        bus.shoot_x = '0;
        bus.shoot_y = '0;
        bus.x_me    = 10'd100;
        bus.y_me    = 9'd50;
        repeat (2) @(negedge clk);
        step(0, 0, 0, 0);
        reset = 1'b1;
        step(0, 1, 100, 50);
        step(1, 0, 0, 0);
        chk("start_alive", 32'(bus.alive), 32'd1);

        step(0, 1, 100, 50);
        t_flash = cyc;
        chk("hit1_score", 32'(bus.score_bcd), 32'h000001);
        step(0, 0, 0, 0);
        for (int i = 0; i < 20 && !bus.alive; i++) step(0, 0, 0, 0);
        chk("respawn_gap", 32'(cyc - t_flash), 32'd12);

        step(0, 1, 99, 50);
        step(0, 1, 132, 50);
        step(0, 1, 100, 82);
        step(0, 1, 131, 81);
        chk("hit2_score", 32'(bus.score_bcd), 32'h000002);
        step(0, 1, 110, 60);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 110, 60);
        chk("dead_shot", 32'(bus.hit), 32'd0);
        wait_alive();

        preload(9, 24'h000009);
        step(0, 1, 110, 60);
        chk("carry1", 32'(bus.score_bcd), 32'h000010);
        wait_alive();
        preload(99999, 24'h099999);
        step(0, 1, 110, 60);
        chk("carry5", 32'(bus.score_bcd), 32'h100000);
        wait_alive();
        preload(999999, 24'h999999);
        step(0, 1, 110, 60);
        chk("sat_score", 32'(bus.score_bcd), 32'h999999);
        chk("sat_hit", 32'(bus.hit), 32'd1);
        wait_alive();

        preload(5, 24'h000005);
        step(1, 1, 110, 60);
        chk("start_prio", 32'(bus.score_bcd), 32'h000000);

        step(0, 1, 110, 60);
        for (int i = 0; i < F + 2; i++) step(0, 0, 0, 0);
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_alive", 32'(bus.alive), 32'd0);
        chk("async_flash", 32'(bus.flash), 32'd0);
        chk("async_score", 32'(bus.score_bcd), 32'd0);
        step(0, 0, 0, 0);
        reset = 1'b1;
        step(0, 1, 110, 60);
        chk("idle_shot", 32'(bus.hit), 32'd0);

        step(1, 0, 0, 0);
        bus.x_me = 10'd620;
        bus.y_me = 9'd470;
        step(0, 1, 645, 495);
        chk("edge_box", 32'(bus.hit), 32'd1);
        wait_alive();

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                bus.x_me = 10'($urandom_range(0, 639));
                bus.y_me = 9'($urandom_range(0, 479));
            end
            xm = int'(bus.x_me) - 3 + int'($urandom_range(0, 37));
            ym = int'(bus.y_me) - 3 + int'($urandom_range(0, 37));
            xm = xm < 0 ? 0 : (xm > 1023 ? 1023 : xm);
            ym = ym < 0 ? 0 : (ym > 511 ? 511 : ym);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, xm, ym);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
